axi_dmem_slave: RTL and testbench

//  AXI4 responder (subordinate) that fronts the data memory: a DEPTH x 32-bit word array.

---
 rtl/axi_dmem_slave_if.sv | 68 ++++++
 rtl/axi_dmem_slave.sv | 270 +++++++++++++++++++++++++++
 tb/tb_axi_dmem_slave.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_dmem_slave_if.sv
// AXI4 bus bundle between the data-cache controller (master) and the
// data-memory responder (slave). Clock and reset are not part of it.
interface axi_dmem_slave_if;

   // write address channel
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic [3:0]  awcache;
   logic        awvalid;
   logic        awready;

   // write data channel
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;

   // write response channel
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   // read address channel
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [3:0]  arcache;
   logic        arvalid;
   logic        arready;

   // read data channel
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   modport master (
      output awaddr, awlen, awsize, awburst, awcache, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bresp, bvalid,
      output bready,
      output araddr, arlen, arsize, arburst, arcache, arvalid,
      input  arready,
      input  rdata, rresp, rlast, rvalid,
      output rready
   );

   modport slave (
      input  awaddr, awlen, awsize, awburst, awcache, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bresp, bvalid,
      input  bready,
      input  araddr, arlen, arsize, arburst, arcache, arvalid,
      output arready,
      output rdata, rresp, rlast, rvalid,
      input  rready
   );

endinterface

// File: rtl/axi_dmem_slave.sv
// AXI4 responder in front of a DEPTH x 32-bit data memory.
// Independent write (AW/W/B) and read (AR/R) state machines share the array.
// All handshake outputs are registered; FIXED and INCR bursts up to 256 beats,
// byte strobes, and SLVERR for out-of-range beats or unsupported size/burst.
module axi_dmem_slave #(
   parameter int          DEPTH     = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter              INIT_FILE = ""
) (
   input  logic             clk,
   input  logic             rst_n,
   axi_dmem_slave_if.slave  bus
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [1:0] W_IDLE = 2'd0;
   localparam logic [1:0] W_DATA = 2'd1;
   localparam logic [1:0] W_RESP = 2'd2;

   localparam logic [0:0] R_IDLE = 1'b0;
   localparam logic [0:0] R_DATA = 1'b1;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [1:0] BURST_INCR = 2'b01;

   // storage; never cleared by reset
   logic [31:0] mem [DEPTH];

   // cache attributes carry no meaning for a plain memory
   logic unused_cache;
   assign unused_cache = ^{bus.awcache, bus.arcache};

   // byte address -> word index; addresses below BASE_ADDR wrap to huge indices
   function automatic logic [31:0] addr_to_idx(input logic [31:0] addr);
      logic [31:0] offs;
      offs = addr - BASE_ADDR;
      return offs >> 2;
   endfunction

   function automatic logic idx_bad(input logic [31:0] idx);
      return idx >= 32'(DEPTH);
   endfunction

   // only 4-byte beats and FIXED/INCR bursts are supported
   function automatic logic hdr_bad(input logic [2:0] size, input logic [1:0] burst);
      return (size != 3'd2) || burst[1];
   endfunction

   // ------------------------------------------------------------------
   // write side state
   // ------------------------------------------------------------------
   logic [1:0]  w_state;
   logic [31:0] w_idx;
   logic [7:0]  w_len;
   logic [7:0]  w_beat;
   logic        w_incr;
   logic        w_hdr_err;
   logic        w_err;

   logic aw_fire;
   logic w_fire;
   logic b_fire;
   logic w_beat_err;
   logic w_last_beat;
   logic w_last_bad;
   logic [31:0] aw_idx;
   logic aw_hdr_err;

   // decode the current write beat and the incoming AW request
   always_comb begin
      aw_fire     = 1'b0;
      w_fire      = 1'b0;
      b_fire      = 1'b0;
      w_beat_err  = 1'b0;
      w_last_beat = 1'b0;
      w_last_bad  = 1'b0;
      aw_idx      = 32'd0;
      aw_hdr_err  = 1'b0;

      aw_fire     = bus.awvalid & bus.awready;
      w_fire      = bus.wvalid & bus.wready;
      b_fire      = bus.bvalid & bus.bready;
      w_beat_err  = w_hdr_err | idx_bad(w_idx);
      w_last_beat = (w_beat == w_len);
      w_last_bad  = (bus.wlast != w_last_beat);
      aw_idx      = addr_to_idx(bus.awaddr);
      aw_hdr_err  = hdr_bad(bus.awsize, bus.awburst);
   end

   // write FSM: accept address, collect len+1 beats, then hold the response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_state     <= W_IDLE;
         w_idx       <= 32'd0;
         w_len       <= 8'd0;
         w_beat      <= 8'd0;
         w_incr      <= 1'b0;
         w_hdr_err   <= 1'b0;
         w_err       <= 1'b0;
         bus.awready <= 1'b0;
         bus.wready  <= 1'b0;
         bus.bvalid  <= 1'b0;
         bus.bresp   <= RESP_OKAY;
      end else begin
         case (w_state)
            W_IDLE: begin
               if (aw_fire) begin
                  bus.awready <= 1'b0;
                  bus.wready  <= 1'b1;
                  w_idx       <= aw_idx;
                  w_len       <= bus.awlen;
                  w_beat      <= 8'd0;
                  w_incr      <= (bus.awburst == BURST_INCR);
                  w_hdr_err   <= aw_hdr_err;
                  w_err       <= aw_hdr_err;
                  w_state     <= W_DATA;
               end else begin
                  bus.awready <= 1'b1;
               end
            end
            W_DATA: begin
               if (w_fire) begin
                  if (w_beat_err || w_last_bad) begin
                     w_err <= 1'b1;
                  end
                  if (w_last_beat) begin
                     bus.wready <= 1'b0;
                     bus.bvalid <= 1'b1;
                     bus.bresp  <= (w_err || w_beat_err || w_last_bad) ? RESP_SLVERR : RESP_OKAY;
                     w_state    <= W_RESP;
                  end else begin
                     w_beat <= w_beat + 8'd1;
                     if (w_incr) begin
                        w_idx <= w_idx + 32'd1;
                     end
                  end
               end
            end
            W_RESP: begin
               if (b_fire) begin
                  bus.bvalid  <= 1'b0;
                  bus.bresp   <= RESP_OKAY;
                  bus.awready <= 1'b1;
                  w_state     <= W_IDLE;
               end
            end
            default: begin
               bus.awready <= 1'b0;
               bus.wready  <= 1'b0;
               bus.bvalid  <= 1'b0;
               bus.bresp   <= RESP_OKAY;
               w_state     <= W_IDLE;
            end
         endcase
      end
   end

   // byte-lane writes; error beats leave the array untouched
   always_ff @(posedge clk) begin
      if (w_fire && !w_beat_err) begin
         for (int k = 0; k < 4; k++) begin
            if (bus.wstrb[k]) begin
               mem[w_idx[IW-1:0]][8*k +: 8] <= bus.wdata[8*k +: 8];
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // read side state
   // ------------------------------------------------------------------
   logic [0:0]  r_state;
   logic [31:0] r_idx;
   logic [7:0]  r_len;
   logic [7:0]  r_beat;
   logic        r_incr;
   logic        r_hdr_err;

   logic        ar_fire;
   logic        r_fire;
   logic [31:0] ar_idx;
   logic        ar_hdr_err;
   logic        ar_err;
   logic [31:0] r_next_idx;
   logic        r_next_err;

   // decode the incoming AR request and the index of the following beat
   always_comb begin
      ar_fire    = 1'b0;
      r_fire     = 1'b0;
      ar_idx     = 32'd0;
      ar_hdr_err = 1'b0;
      ar_err     = 1'b0;
      r_next_idx = 32'd0;
      r_next_err = 1'b0;

      ar_fire    = bus.arvalid & bus.arready;
      r_fire     = bus.rvalid & bus.rready;
      ar_idx     = addr_to_idx(bus.araddr);
      ar_hdr_err = hdr_bad(bus.arsize, bus.arburst);
      ar_err     = ar_hdr_err | idx_bad(ar_idx);
      r_next_idx = r_incr ? (r_idx + 32'd1) : r_idx;
      r_next_err = r_hdr_err | idx_bad(r_next_idx);
   end

   // read FSM: register one beat per accepted R transfer, so rvalid stays up at full rate
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= R_IDLE;
         r_idx       <= 32'd0;
         r_len       <= 8'd0;
         r_beat      <= 8'd0;
         r_incr      <= 1'b0;
         r_hdr_err   <= 1'b0;
         bus.arready <= 1'b0;
         bus.rvalid  <= 1'b0;
         bus.rlast   <= 1'b0;
         bus.rresp   <= RESP_OKAY;
         bus.rdata   <= 32'd0;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (ar_fire) begin
                  bus.arready <= 1'b0;
                  bus.rvalid  <= 1'b1;
                  bus.rdata   <= ar_err ? 32'd0 : mem[ar_idx[IW-1:0]];
                  bus.rresp   <= ar_err ? RESP_SLVERR : RESP_OKAY;
                  bus.rlast   <= (bus.arlen == 8'd0);
                  r_idx       <= ar_idx;
                  r_len       <= bus.arlen;
                  r_beat      <= 8'd0;
                  r_incr      <= (bus.arburst == BURST_INCR);
                  r_hdr_err   <= ar_hdr_err;
                  r_state     <= R_DATA;
               end else begin
                  bus.arready <= 1'b1;
               end
            end
            R_DATA: begin
               if (r_fire) begin
                  if (r_beat == r_len) begin
                     bus.rvalid  <= 1'b0;
                     bus.rlast   <= 1'b0;
                     bus.rresp   <= RESP_OKAY;
                     bus.rdata   <= 32'd0;
                     bus.arready <= 1'b1;
                     r_state     <= R_IDLE;
                  end else begin
                     bus.rdata <= r_next_err ? 32'd0 : mem[r_next_idx[IW-1:0]];
                     bus.rresp <= r_next_err ? RESP_SLVERR : RESP_OKAY;
                     bus.rlast <= ((r_beat + 8'd1) == r_len);
                     r_idx     <= r_next_idx;
                     r_beat    <= r_beat + 8'd1;
                  end
               end
            end
            default: begin
               bus.arready <= 1'b0;
               bus.rvalid  <= 1'b0;
               bus.rlast   <= 1'b0;
               r_state     <= R_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi_dmem_slave.sv
// Directed self-checking bench for axi_dmem_slave.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_axi_dmem_slave;

   localparam int DEPTH = 256;

   logic clk = 1'b0;
   logic rst_n = 1'b1;

   // free-running clock, 10 time-unit period
   always #5 clk = ~clk;

   axi_dmem_slave_if bus();

   axi_dmem_slave #(
      .DEPTH     (DEPTH),
      .BASE_ADDR (32'h0000_0000),
      .INIT_FILE ("")
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   logic [31:0] beatData [256];
   logic [3:0]  beatStrb [256];
   logic [31:0] expData  [256];
   logic [1:0]  expResp  [256];

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
      end
   endtask

   task automatic writeBurst(input logic [31:0] addr, input int len, input logic [1:0] burst,
                             input logic [2:0] size, input logic badLast, input logic [1:0] wantResp);
      @(negedge clk);
      bus.awaddr  = addr;
      bus.awlen   = len[7:0];
      bus.awsize  = size;
      bus.awburst = burst;
      bus.awvalid = 1'b1;
      for (int i = 0; i < 20 && !bus.awready; i++) @(negedge clk);
      checkOutput("awready", {31'd0, bus.awready}, 32'd1);
      @(negedge clk);
      bus.awvalid = 1'b0;
      checkOutput("wready_latency", {31'd0, bus.wready}, 32'd1);
      for (int b = 0; b <= len; b++) begin
         bus.wvalid = 1'b1;
         bus.wdata  = beatData[b];
         bus.wstrb  = beatStrb[b];
         bus.wlast  = (b == len) ^ badLast;
         for (int i = 0; i < 20 && !bus.wready; i++) @(negedge clk);
         checkOutput("wready", {31'd0, bus.wready}, 32'd1);
         @(negedge clk);
      end
      bus.wvalid = 1'b0;
      bus.wlast  = 1'b0;
      checkOutput("wready_drop", {31'd0, bus.wready}, 32'd0);
      checkOutput("bvalid_latency", {31'd0, bus.bvalid}, 32'd1);
      checkOutput("bresp", {30'd0, bus.bresp}, {30'd0, wantResp});
      bus.bready = 1'b1;
      @(negedge clk);
      bus.bready = 1'b0;
      checkOutput("bvalid_drop", {31'd0, bus.bvalid}, 32'd0);
   endtask

   task automatic readBurst(input logic [31:0] addr, input int len, input logic [1:0] burst,
                            input logic [2:0] size, input logic toggle);
      @(negedge clk);
      bus.araddr  = addr;
      bus.arlen   = len[7:0];
      bus.arsize  = size;
      bus.arburst = burst;
      bus.arvalid = 1'b1;
      for (int i = 0; i < 20 && !bus.arready; i++) @(negedge clk);
      checkOutput("arready", {31'd0, bus.arready}, 32'd1);
      @(negedge clk);
      bus.arvalid = 1'b0;
      checkOutput("rvalid_latency", {31'd0, bus.rvalid}, 32'd1);
      for (int b = 0; b <= len; b++) begin
         if (toggle) begin
            bus.rready = 1'b0;
            checkOutput("rdata_stall", bus.rdata, expData[b]);
            checkOutput("rlast_stall", {31'd0, bus.rlast}, {31'd0, b == len});
            @(negedge clk);
         end
         bus.rready = 1'b1;
         for (int i = 0; i < 20 && !bus.rvalid; i++) @(negedge clk);
         checkOutput("rvalid", {31'd0, bus.rvalid}, 32'd1);
         checkOutput("rdata", bus.rdata, expData[b]);
         checkOutput("rresp", {30'd0, bus.rresp}, {30'd0, expResp[b]});
         checkOutput("rlast", {31'd0, bus.rlast}, {31'd0, b == len});
         @(negedge clk);
      end
      bus.rready = 1'b0;
      checkOutput("rvalid_drop", {31'd0, bus.rvalid}, 32'd0);
      checkOutput("rlast_drop", {31'd0, bus.rlast}, 32'd0);
   endtask

   task automatic applyStimulus();
      // reset state
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("rst_awready", {31'd0, bus.awready}, 32'd0);
      checkOutput("rst_wready",  {31'd0, bus.wready},  32'd0);
      checkOutput("rst_bvalid",  {31'd0, bus.bvalid},  32'd0);
      checkOutput("rst_arready", {31'd0, bus.arready}, 32'd0);
      checkOutput("rst_rvalid",  {31'd0, bus.rvalid},  32'd0);
      checkOutput("rst_rlast",   {31'd0, bus.rlast},   32'd0);
      checkOutput("rst_bresp",   {30'd0, bus.bresp},   32'd0);
      checkOutput("rst_rresp",   {30'd0, bus.rresp},   32'd0);
      checkOutput("rst_rdata",   bus.rdata,            32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("post_rst_awready", {31'd0, bus.awready}, 32'd1);
      checkOutput("post_rst_arready", {31'd0, bus.arready}, 32'd1);

      // single-beat write and readback
      beatData[0] = 32'hDEAD_BEEF; beatStrb[0] = 4'hF;
      writeBurst(32'h10, 0, 2'b01, 3'd2, 1'b0, 2'b00);
      expData[0] = 32'hDEAD_BEEF; expResp[0] = 2'b00;
      readBurst(32'h10, 0, 2'b01, 3'd2, 1'b0);

      // byte strobes merge into the existing word
      beatData[0] = 32'h1122_3344; beatStrb[0] = 4'hF;
      writeBurst(32'h20, 0, 2'b01, 3'd2, 1'b0, 2'b00);
      beatData[0] = 32'hAABB_CCDD; beatStrb[0] = 4'b0101;
      writeBurst(32'h20, 0, 2'b01, 3'd2, 1'b0, 2'b00);
      expData[0] = 32'h11BB_33DD;
      readBurst(32'h20, 0, 2'b01, 3'd2, 1'b0);

      // INCR burst, read back with rready toggling
      for (int b = 0; b < 4; b++) begin
         beatData[b] = 32'(b + 1); beatStrb[b] = 4'hF;
         expData[b]  = 32'(b + 1); expResp[b]  = 2'b00;
      end
      writeBurst(32'h40, 3, 2'b01, 3'd2, 1'b0, 2'b00);
      readBurst(32'h40, 3, 2'b01, 3'd2, 1'b1);

      // FIXED burst writes the same word each beat; last one wins
      beatData[0] = 32'hA; beatData[1] = 32'hB; beatData[2] = 32'hC;
      writeBurst(32'h60, 2, 2'b00, 3'd2, 1'b0, 2'b00);
      expData[0] = 32'hC; expData[1] = 32'hC;
      readBurst(32'h60, 1, 2'b00, 3'd2, 1'b0);

      // out of range and last-word boundary
      beatData[0] = 32'h0BAD_F00D; beatStrb[0] = 4'hF;
      writeBurst(32'h3FC, 0, 2'b01, 3'd2, 1'b0, 2'b00);
      expData[0] = 32'd0; expResp[0] = 2'b10;
      readBurst(32'h400, 0, 2'b01, 3'd2, 1'b0);
      beatData[0] = 32'h1234_5678;
      writeBurst(32'h400, 0, 2'b01, 3'd2, 1'b0, 2'b10);
      expData[0] = 32'h0BAD_F00D; expResp[0] = 2'b00;
      readBurst(32'h3FC, 0, 2'b01, 3'd2, 1'b0);

      // INCR burst running off the end: first beat lands, second is an error
      beatData[0] = 32'h77; beatData[1] = 32'h88; beatStrb[1] = 4'hF;
      writeBurst(32'h3FC, 1, 2'b01, 3'd2, 1'b0, 2'b10);
      expData[0] = 32'h77; expResp[0] = 2'b00;
      expData[1] = 32'h0;  expResp[1] = 2'b10;
      readBurst(32'h3FC, 1, 2'b01, 3'd2, 1'b0);

      // WRAP read and bad-size write are rejected; bad-size write leaves memory alone
      expData[0] = 32'd0; expResp[0] = 2'b10;
      readBurst(32'h10, 0, 2'b10, 3'd2, 1'b0);
      beatData[0] = 32'h0; beatStrb[0] = 4'hF;
      writeBurst(32'h10, 0, 2'b01, 3'd3, 1'b0, 2'b10);
      expData[0] = 32'hDEAD_BEEF; expResp[0] = 2'b00;
      readBurst(32'h10, 0, 2'b01, 3'd2, 1'b0);

      // wlast on the wrong beat
      beatData[0] = 32'h55; beatStrb[0] = 4'hF;
      writeBurst(32'h30, 0, 2'b01, 3'd2, 1'b1, 2'b10);

      // write and read of the same word on the same edge
      beatData[0] = 32'h9; beatStrb[0] = 4'hF;
      writeBurst(32'h80, 0, 2'b01, 3'd2, 1'b0, 2'b00);
      @(negedge clk);
      bus.awaddr = 32'h80; bus.awlen = 8'd0; bus.awsize = 3'd2; bus.awburst = 2'b01;
      bus.awvalid = 1'b1;
      checkOutput("conc_awready", {31'd0, bus.awready}, 32'd1);
      @(negedge clk);
      bus.awvalid = 1'b0;
      bus.wvalid = 1'b1; bus.wdata = 32'h5; bus.wstrb = 4'hF; bus.wlast = 1'b1;
      bus.araddr = 32'h80; bus.arlen = 8'd0; bus.arsize = 3'd2; bus.arburst = 2'b01;
      bus.arvalid = 1'b1;
      checkOutput("conc_wready",  {31'd0, bus.wready},  32'd1);
      checkOutput("conc_arready", {31'd0, bus.arready}, 32'd1);
      @(negedge clk);
      bus.wvalid = 1'b0; bus.wlast = 1'b0; bus.arvalid = 1'b0;
      checkOutput("conc_rvalid", {31'd0, bus.rvalid}, 32'd1);
      checkOutput("conc_old_data", bus.rdata, 32'h9);
      checkOutput("conc_bvalid", {31'd0, bus.bvalid}, 32'd1);
      bus.rready = 1'b1; bus.bready = 1'b1;
      @(negedge clk);
      bus.rready = 1'b0; bus.bready = 1'b0;
      expData[0] = 32'h5; expResp[0] = 2'b00;
      readBurst(32'h80, 0, 2'b01, 3'd2, 1'b0);

      // reset in the middle of a write burst
      @(negedge clk);
      bus.awaddr = 32'h100; bus.awlen = 8'd3; bus.awsize = 3'd2; bus.awburst = 2'b01;
      bus.awvalid = 1'b1;
      checkOutput("mid_awready", {31'd0, bus.awready}, 32'd1);
      @(negedge clk);
      bus.awvalid = 1'b0;
      bus.wvalid = 1'b1; bus.wdata = 32'h1; bus.wstrb = 4'hF; bus.wlast = 1'b0;
      @(negedge clk);
      checkOutput("mid_wready", {31'd0, bus.wready}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_awready", {31'd0, bus.awready}, 32'd0);
      checkOutput("mid_rst_wready",  {31'd0, bus.wready},  32'd0);
      checkOutput("mid_rst_bvalid",  {31'd0, bus.bvalid},  32'd0);
      bus.wvalid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checkOutput("post_mid_bvalid",  {31'd0, bus.bvalid},  32'd0);
         checkOutput("post_mid_awready", {31'd0, bus.awready}, 32'd1);
         checkOutput("post_mid_wready",  {31'd0, bus.wready},  32'd0);
      end
   endtask

   // main sequence
   initial begin
      bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awcache = '0;
      bus.awvalid = 1'b0;
      bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
      bus.bready = 1'b0;
      bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arcache = '0;
      bus.arvalid = 1'b0;
      bus.rready = 1'b0;
      applyStimulus();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // global time limit
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] time limit reached");
   end

endmodule
